// File: rtl/lcd_hd44780_rx.sv
// HD44780 bus responder: samples RS/E/DB, decodes E falling edges into instruction/data writes.
// Optional feature macro: LCD_RX_BUSY_CHECK_EN (drop writes while busy and pulse overrun).
module lcd_hd44780_rx #(
    parameter int BUSY_SHORT_CYC = 3700,
    parameter int BUSY_LONG_CYC  = 152000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RS,
    input  logic       E,
    input  logic [7:0] DB,
    output logic       ddram_we,
    output logic [6:0] ddram_addr,
    output logic [7:0] ddram_data,
    output logic [6:0] cursor_addr,
    output logic [5:0] shift_offset,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       bus_8bit,
    output logic       two_line,
    output logic       font_5x10,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       overrun
);

    localparam int CNT_MAX = (BUSY_LONG_CYC > BUSY_SHORT_CYC) ? BUSY_LONG_CYC : BUSY_SHORT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SWEEP, S_BUSY} state_t;

    state_t           state, state_nx;
    logic             rs_p0, rs_p1, e_p0, e_p1, e_p2;
    logic [7:0]       db_p0, db_p1;
    logic             rs_hold;
    logic [7:0]       db_hold;
    logic             fall, accept, drop, acc_rs, sweep_last;
    logic [7:0]       acc_db;
    logic             is_clear, is_long;
    logic             exec_we, exec_clear, cgram_mode;
    logic [6:0]       we_addr, sweep_addr;
    logic [7:0]       we_data;
    logic [CNT_W-1:0] busy_cnt;

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == 7'h27)       r = 7'h40;
            else if (inc && a == 7'h67)  r = 7'h00;
            else if (!inc && a == 7'h40) r = 7'h27;
            else if (!inc && a == 7'h00) r = 7'h67;
        end else begin
            if (inc && a == 7'h4F)       r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h4F;
        end
        return r;
    endfunction

    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic inc);
        if (inc) return (s == 6'd39) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    // Pin synchronisers; RS/DB are held from the last sample that still saw E high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_p0   <= 1'b0;
            rs_p1   <= 1'b0;
            e_p0    <= 1'b0;
            e_p1    <= 1'b0;
            e_p2    <= 1'b0;
            db_p0   <= 8'h00;
            db_p1   <= 8'h00;
            rs_hold <= 1'b0;
            db_hold <= 8'h00;
        end else begin
            rs_p0 <= RS;
            rs_p1 <= rs_p0;
            e_p0  <= E;
            e_p1  <= e_p0;
            e_p2  <= e_p1;
            db_p0 <= DB;
            db_p1 <= db_p0;
            if (e_p1) begin
                rs_hold <= rs_p1;
                db_hold <= db_p1;
            end
        end
    end

    assign fall       = e_p2 & ~e_p1;
    assign sweep_last = (state == S_SWEEP) && (sweep_addr == 7'h7F);

`ifdef LCD_RX_BUSY_CHECK_EN
    assign accept = fall && (state == S_IDLE);
    assign drop   = fall && (state != S_IDLE);
    assign acc_rs = rs_hold;
    assign acc_db = db_hold;
`else
    logic       pend_vld, pend_rs;
    logic [7:0] pend_db;

    // Events during the sweep wait in a one-deep slot; a fresh event on the last sweep cycle wins
    always_comb begin
        accept = fall;
        acc_rs = rs_hold;
        acc_db = db_hold;
        if (state == S_SWEEP) begin
            accept = sweep_last && (fall || pend_vld);
            if (!fall) begin
                acc_rs = pend_rs;
                acc_db = pend_db;
            end
        end
    end

    assign drop = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_rs  <= 1'b0;
            pend_db  <= 8'h00;
        end else if (state == S_SWEEP) begin
            if (fall && !sweep_last) begin
                pend_vld <= 1'b1;
                pend_rs  <= rs_hold;
                pend_db  <= db_hold;
            end else if (sweep_last) begin
                pend_vld <= 1'b0;
            end
        end
    end
`endif

    assign is_clear = !acc_rs && (acc_db == 8'h01);
    assign is_long  = !acc_rs && (acc_db[7:1] == 7'h00 && acc_db[0]) || (!acc_rs && acc_db[7:1] == 7'h01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        ddram_we   = 1'b0;
        ddram_addr = we_addr;
        ddram_data = we_data;
        case (state)
            S_EXEC: begin
                ddram_we = exec_we;
                state_nx = exec_clear ? S_SWEEP : S_BUSY;
            end
            S_SWEEP: begin
                ddram_we   = 1'b1;
                ddram_addr = sweep_addr;
                ddram_data = 8'h20;
                if (sweep_last) state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (busy_cnt == '0) state_nx = S_IDLE;
            end
            default: ;
        endcase
        if (accept) state_nx = S_EXEC;
    end

    // Busy countdown is loaded at acceptance so the EXEC cycle is the first busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt   <= '0;
            sweep_addr <= 7'h00;
        end else begin
            if (accept)                                busy_cnt <= is_long ? LONG_LOAD : SHORT_LOAD;
            else if (state != S_IDLE && busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            sweep_addr <= (state == S_SWEEP) ? sweep_addr + 7'd1 : 7'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_we      <= 1'b0;
            exec_clear   <= 1'b0;
            we_addr      <= 7'h00;
            we_data      <= 8'h00;
            cgram_mode   <= 1'b0;
            cursor_addr  <= 7'h00;
            shift_offset <= 6'd0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            entry_inc    <= 1'b1;
            entry_shift  <= 1'b0;
            bus_8bit     <= 1'b1;
            two_line     <= 1'b0;
            font_5x10    <= 1'b0;
            cmd_strobe   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            overrun    <= drop;
            if (accept) begin
                exec_we    <= acc_rs && !cgram_mode;
                exec_clear <= is_clear;
                if (acc_rs) begin
                    if (!cgram_mode) begin
                        we_addr     <= cursor_addr;
                        we_data     <= acc_db;
                        cursor_addr <= addr_step(cursor_addr, entry_inc, two_line);
                        if (entry_shift) shift_offset <= shift_step(shift_offset, entry_inc);
                    end
                end else begin
                    cmd_strobe <= 1'b1;
                    casez (acc_db)
                        8'b1???????: begin
                            cursor_addr <= acc_db[6:0];
                            cgram_mode  <= 1'b0;
                        end
                        8'b01??????: cgram_mode <= 1'b1;
                        8'b001?????: {bus_8bit, two_line, font_5x10} <= acc_db[4:2];
                        8'b0001????: begin
                            if (acc_db[3]) shift_offset <= shift_step(shift_offset, acc_db[2]);
                            else           cursor_addr  <= addr_step(cursor_addr, acc_db[2], two_line);
                        end
                        8'b00001???: {display_on, cursor_on, blink_on} <= acc_db[2:0];
                        8'b000001??: {entry_inc, entry_shift} <= acc_db[1:0];
                        8'b0000001?: begin
                            cursor_addr  <= 7'h00;
                            shift_offset <= 6'd0;
                            cgram_mode   <= 1'b0;
                        end
                        8'b00000001: begin
                            cursor_addr  <= 7'h00;
                            shift_offset <= 6'd0;
                            cgram_mode   <= 1'b0;
                            entry_inc    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
